// File: rtl/axi_lite_gpio_pkg.sv
// rtl/axi_lite_gpio_pkg.sv - shared constants and channel decode for the AXI-Lite GPIO block
package axi_lite_gpio_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int          MAX_PORTS          = 4;
    localparam logic [31:0] DEFAULT_GPO_OFFSET = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_GPI_OFFSET = 32'h0000_0010;
    localparam int          DEFAULT_ADDR_INC   = 4;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } decode_t;

    // Word-aligned match of addr against offset + k*inc for the first count channels.
    function automatic decode_t decode_ch(
        input logic [31:0] addr,
        input logic [31:0] offset,
        input logic [31:0] inc,
        input int          count
    );
        decode_t r;
        r = '0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (k < count &&
                {addr[31:2], 2'b00} == ((offset + 32'(k) * inc) & 32'hFFFF_FFFC)) begin
                r.hit = 1'b1;
                r.idx = 2'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_gpio_wr_ch.sv
// rtl/axi_lite_gpio_wr_ch.sv - AW/W capture, join and B response for the GPIO slave
module axi_lite_gpio_wr_ch
    import axi_lite_gpio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output logic        wr_commit,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb,
    input  logic        wr_ok
);

    logic aw_captured, w_captured;
    logic aw_hs, w_hs;
    logic aw_cap_n, w_cap_n, bvalid_n;

    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign wr_commit = aw_captured & w_captured;

    always_comb begin
        aw_cap_n = wr_commit ? 1'b0 : (aw_captured | aw_hs);
        w_cap_n  = wr_commit ? 1'b0 : (w_captured | w_hs);
        bvalid_n = wr_commit | (bvalid & ~bready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            awready     <= 1'b0;
            wready      <= 1'b0;
            bvalid      <= 1'b0;
            bresp       <= RESP_OKAY;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_strb     <= '0;
        end else begin
            aw_captured <= aw_cap_n;
            w_captured  <= w_cap_n;
            bvalid      <= bvalid_n;
            // Readies are computed from next state so they never accept a beat that would be dropped.
            awready     <= ~aw_cap_n & ~bvalid_n;
            wready      <= ~w_cap_n & ~bvalid_n;
            if (aw_hs) wr_addr <= awaddr;
            if (w_hs) begin
                wr_data <= wdata;
                wr_strb <= wstrb;
            end
            if (wr_commit) bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule

// File: rtl/axi_lite_gpio.sv
// rtl/axi_lite_gpio.sv - AXI4-Lite slave with up to four GPO registers and four GPI ports
module axi_lite_gpio
    import axi_lite_gpio_pkg::*;
#(
    parameter int          I_PORT_COUNT        = 1,
    parameter int          O_PORT_COUNT        = 1,
    parameter logic [31:0] GPO_AXI_ADDR_OFFSET = DEFAULT_GPO_OFFSET,
    parameter logic [31:0] GPI_AXI_ADDR_OFFSET = DEFAULT_GPI_OFFSET,
    parameter int          ADDR_INC            = DEFAULT_ADDR_INC
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_areset,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    output logic [31:0] out0,
    output logic [31:0] out1,
    output logic [31:0] out2,
    output logic [31:0] out3
);

    logic [31:0] out_regs [MAX_PORTS];
    logic [31:0] in_arr   [MAX_PORTS];

    logic        wr_commit;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    decode_t     wr_dec, rd_gpi, rd_gpo;
    logic        ar_hs, rvalid_n;
    logic        unused;

    assign unused = ^{s_axi_awprot, s_axi_arprot};

    assign in_arr[0] = in0;
    assign in_arr[1] = in1;
    assign in_arr[2] = in2;
    assign in_arr[3] = in3;

    assign out0 = out_regs[0];
    assign out1 = (O_PORT_COUNT > 1) ? out_regs[1] : '0;
    assign out2 = (O_PORT_COUNT > 2) ? out_regs[2] : '0;
    assign out3 = (O_PORT_COUNT > 3) ? out_regs[3] : '0;

    axi_lite_gpio_wr_ch u_wr_ch (
        .clk       (s_axi_aclk),
        .reset     (s_axi_areset),
        .awaddr    (s_axi_awaddr),
        .awvalid   (s_axi_awvalid),
        .awready   (s_axi_awready),
        .wdata     (s_axi_wdata),
        .wstrb     (s_axi_wstrb),
        .wvalid    (s_axi_wvalid),
        .wready    (s_axi_wready),
        .bresp     (s_axi_bresp),
        .bvalid    (s_axi_bvalid),
        .bready    (s_axi_bready),
        .wr_commit (wr_commit),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .wr_ok     (wr_dec.hit)
    );

    assign wr_dec = decode_ch(wr_addr, GPO_AXI_ADDR_OFFSET, 32'(ADDR_INC), O_PORT_COUNT);
    assign rd_gpi = decode_ch(s_axi_araddr, GPI_AXI_ADDR_OFFSET, 32'(ADDR_INC), I_PORT_COUNT);
    assign rd_gpo = decode_ch(s_axi_araddr, GPO_AXI_ADDR_OFFSET, 32'(ADDR_INC), O_PORT_COUNT);

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            for (int k = 0; k < MAX_PORTS; k++) out_regs[k] <= '0;
        end else if (wr_commit && wr_dec.hit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) out_regs[wr_dec.idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign ar_hs    = s_axi_arvalid & s_axi_arready;
    assign rvalid_n = ar_hs | (s_axi_rvalid & ~s_axi_rready);

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            s_axi_rvalid  <= rvalid_n;
            s_axi_arready <= ~rvalid_n;
            if (ar_hs) begin
                if (rd_gpi.hit) begin
                    s_axi_rdata <= in_arr[rd_gpi.idx];
                    s_axi_rresp <= RESP_OKAY;
                end else if (rd_gpo.hit) begin
                    s_axi_rdata <= out_regs[rd_gpo.idx];
                    s_axi_rresp <= RESP_OKAY;
                end else begin
                    s_axi_rdata <= '0;
                    s_axi_rresp <= RESP_SLVERR;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_gpio.sv
// tb/tb_axi_lite_gpio.sv - self-checking bench for axi_lite_gpio with default parameters
module tb_axi_lite_gpio;

    logic        clk = 1'b0;
    logic        s_axi_areset;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] in0, in1, in2, in3;
    logic [31:0] out0, out1, out2, out3;

    always #5 clk = ~clk;

    axi_lite_gpio dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (s_axi_areset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .in0           (in0),
        .in1           (in1),
        .in2           (in2),
        .in3           (in3),
        .out0          (out0),
        .out1          (out1),
        .out2          (out2),
        .out3          (out3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_out [4];

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lead;
        logic [31:0] raddr;
        logic [31:0] in0v;
        logic [1:0]  eb;
        logic [1:0]  er;
        logic [31:0] erd;
        logic [31:0] eout;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel index of addr in a bank of count 4-byte channels starting at base, or -1.
    function automatic int chan(input logic [31:0] addr, input logic [31:0] base, input int count);
        logic [31:0] a;
        a = addr & 32'hFFFF_FFFC;
        if (a < base) return -1;
        if (((a - base) % 4) != 0) return -1;
        if (((a - base) / 4) >= 32'(count)) return -1;
        return int'((a - base) / 4);
    endfunction

    // lead: 0 = AW and W together, 1 = W one cycle early, -1 = AW one cycle early
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        resp = 2'bxx;
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        if (lead >= 0) s_axi_wvalid = 1'b1;
        if (lead <= 0) s_axi_awvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            tick();
            cyc++;
            if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  s_axi_wvalid  = 1'b0; end
            if (cyc == 1) begin
                if (!aw_done && !s_axi_awvalid) s_axi_awvalid = 1'b1;
                if (!w_done && !s_axi_wvalid)   s_axi_wvalid  = 1'b1;
            end
        end
        if (!(aw_done && w_done)) begin
            timeout("aw_w_accept");
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            return;
        end
        s_axi_bready = 1'b1;
        cyc = 0;
        while (!s_axi_bvalid && cyc < 20) begin tick(); cyc++; end
        if (!s_axi_bvalid) timeout("bvalid");
        else begin
            resp = s_axi_bresp;
            tick();
        end
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit hs = 0;
        int cyc = 0;
        data = 'x;
        resp = 2'bxx;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        while (!hs && cyc < 20) begin
            hs = s_axi_arvalid && s_axi_arready;
            tick();
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        if (!hs) begin timeout("ar_accept"); return; end
        s_axi_rready = 1'b1;
        cyc = 0;
        while (!s_axi_rvalid && cyc < 20) begin tick(); cyc++; end
        if (!s_axi_rvalid) timeout("rvalid");
        else begin
            data = s_axi_rdata;
            resp = s_axi_rresp;
            tick();
        end
        s_axi_rready = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0: a = 32'h00;
            1: a = 32'h04;
            2: a = 32'h08;
            3: a = 32'h0C;
            4: a = 32'h10;
            5: a = 32'h14;
            6: a = 32'h18;
            default: a = $urandom;
        endcase
        return a | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  b, r;
        logic [31:0] d, ra, wa, wd;
        logic [3:0]  ws;
        int          k, cyc;

        vt[0] = '{32'h04, 32'hBABACECE, 4'hF,  0, 32'h14, 32'h0000CE00, 2'b10, 2'b10, 32'h0,        32'hDEADBEEF};
        vt[1] = '{32'h00, 32'h0BEEC0C0, 4'hF,  1, 32'h10, 32'h0000CE00, 2'b00, 2'b00, 32'h0000CE00, 32'h0BEEC0C0};
        vt[2] = '{32'h00, 32'hDEADBEEF, 4'hF, -1, 32'h10, 32'h0000CE01, 2'b00, 2'b00, 32'h0000CE01, 32'hDEADBEEF};
        vt[3] = '{32'h10, 32'h12345678, 4'hF,  0, 32'h00, 32'h0000CE00, 2'b10, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF};
        vt[4] = '{32'h00, 32'hFFFFFFFF, 4'h3,  0, 32'h13, 32'h0000A5A5, 2'b00, 2'b00, 32'h0000A5A5, 32'hDEADFFFF};
        vt[5] = '{32'h03, 32'h00000000, 4'h8,  0, 32'h20, 32'h0000A5A5, 2'b00, 2'b10, 32'h0,        32'h00ADFFFF};

        s_axi_areset = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        in0 = 32'h0000CE00; in1 = 32'h11111111; in2 = 32'h22222222; in3 = 32'h33333333;
        tick(); tick();
        check("reset_out0", out0, 32'h0);
        check("reset_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'h0);
        check("reset_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h0);
        check("reset_resp_rdata", 32'({s_axi_bresp, s_axi_rresp}) | s_axi_rdata, 32'h0);
        s_axi_areset = 1'b0;

        // Simultaneous AW/W/AR, then B and R stalls.
        s_axi_awaddr = 32'h00; s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_araddr = 32'h10;
        cyc = 0;
        while (!(s_axi_awready && s_axi_wready && s_axi_arready) && cyc < 10) begin tick(); cyc++; end
        check("idle_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        check("out0_not_yet", out0, 32'h0);
        check("rvalid_after_ar", 32'(s_axi_rvalid), 32'h1);
        check("rdata_gpi0", s_axi_rdata, 32'h0000CE00);
        check("rresp_gpi0", 32'(s_axi_rresp), 32'h0);
        check("readies_low_after_hs", 32'({s_axi_awready, s_axi_wready, s_axi_bvalid}), 32'h0);
        tick();
        check("out0_written", out0, 32'hDEADBEEF);
        check("bvalid_set", 32'(s_axi_bvalid), 32'h1);
        check("bresp_okay", 32'(s_axi_bresp), 32'h0);
        tick(); tick();
        check("bvalid_held", 32'(s_axi_bvalid), 32'h1);
        check("aw_w_blocked", 32'({s_axi_awready, s_axi_wready}), 32'h0);
        s_axi_arvalid = 1'b1;
        check("arready_low_while_rvalid", 32'(s_axi_arready), 32'h0);
        in0 = 32'h11112222;
        tick();
        s_axi_arvalid = 1'b0;
        check("rvalid_held", 32'(s_axi_rvalid), 32'h1);
        check("rdata_held", s_axi_rdata, 32'h0000CE00);
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        tick();
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        check("b_r_drained", 32'({s_axi_bvalid, s_axi_rvalid}), 32'h0);
        check("readies_back", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
        tick();
        check("second_ar_dropped", 32'(s_axi_rvalid), 32'h0);

        foreach (vt[i]) begin
            in0 = vt[i].in0v;
            fork
                axi_write(vt[i].waddr, vt[i].wdata, vt[i].wstrb, vt[i].lead, b);
                axi_read(vt[i].raddr, d, r);
            join
            check($sformatf("vec%0d_bresp", i), 32'(b), 32'(vt[i].eb));
            check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vt[i].er));
            check($sformatf("vec%0d_rdata", i), d, vt[i].erd);
            check($sformatf("vec%0d_out0", i), out0, vt[i].eout);
        end

        // Reset with an address captured but no data aborts the write.
        s_axi_awaddr = 32'h00; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_areset = 1'b1;
        tick();
        check("rst2_out0", out0, 32'h0);
        check("rst2_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'h0);
        check("rst2_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h0);
        s_axi_areset = 1'b0;
        tick();
        check("rst2_no_bvalid", 32'(s_axi_bvalid), 32'h0);
        for (int j = 0; j < 4; j++) m_out[j] = '0;

        for (int it = 0; it < 150; it++) begin
            wa = pick_addr();
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            in0 = $urandom; in1 = $urandom; in2 = $urandom; in3 = $urandom;
            axi_write(wa, wd, ws, $urandom_range(0, 2) - 1, b);
            k = chan(wa, 32'h00, 1);
            if (k >= 0) begin
                for (int by = 0; by < 4; by++)
                    if (ws[by]) m_out[k][8*by +: 8] = wd[8*by +: 8];
            end
            check("rnd_bresp", 32'(b), (k >= 0) ? 32'h0 : 32'h2);
            check("rnd_out0", out0, m_out[0]);
            ra = pick_addr();
            axi_read(ra, d, r);
            if (chan(ra, 32'h10, 1) >= 0) begin
                check("rnd_rresp", 32'(r), 32'h0);
                check("rnd_rdata_gpi", d, in0);
            end else if (chan(ra, 32'h00, 1) >= 0) begin
                check("rnd_rresp", 32'(r), 32'h0);
                check("rnd_rdata_gpo", d, m_out[0]);
            end else begin
                check("rnd_rresp", 32'(r), 32'h2);
                check("rnd_rdata_err", d, 32'h0);
            end
        end
        check("unused_outs_zero", out1 | out2 | out3, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
